cla5_accumulator: RTL
=====================

Name: cla5_accumulator

Overview:
- Registered 5-bit accumulator stage that consumes the carry-lookahead adder's output and registers it.
- Captures an operand and opcode through a valid/ready handshake, computes ACC op DIN through the ripple-free CLA datapath, and latches the result and carry/borrow into edge-triggered state.
- Provides the sequential wrapper that turns the combinational adder into a usable datapath stage with backpressure.

Parameters:
- WIDTH, 5, datapath width of DIN and ACC in bits (the CLA slice width).

Ports:
- CLK  input  1  single clock, all state updates on the rising edge.
- RSTN  input  1  asynchronous active-low reset; clears all state immediately on assertion, released synchronously by the environment.
- IN_VALID  input  1  upstream presents OP/DIN.
- IN_READY  output  1  block can accept a new operation.
- OP  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- DIN  input  WIDTH  unsigned operand.
- OUT_VALID  output  1  ACC/C hold a fresh result.
- OUT_READY  input  1  downstream consumes the result.
- ACC  output  WIDTH  accumulator value (registered).
- C  output  1  carry (ADD) or borrow (SUB) of the last operation, 0 for LOAD/CLEAR.
- OVF_STICKY  output  1  set by any C=1 result, cleared only by CLEAR or reset.

Behaviour:
- Reset (RSTN=0, asynchronous): state=IDLE, ACC=0, C=0, OVF_STICKY=0, OUT_VALID=0, operand/opcode registers=0. IN_READY=0 while RSTN=0. Reset mid-COMPUTE or mid-HOLD discards the operation; no result is produced.
- FSM states:
  - IDLE: IN_READY=1. On IN_VALID&IN_READY, capture OP and DIN into operand registers and go to COMPUTE.
  - COMPUTE: IN_READY=0. On the edge leaving COMPUTE, update ACC and C, update OVF_STICKY, set OUT_VALID=1, and go to HOLD.
  - HOLD: IN_READY=0, OUT_VALID=1. ACC and C are stable. When OUT_READY=1 at an edge, clear OUT_VALID and return to IDLE.
- Latency and throughput:
  - Accept at edge k gives OUT_VALID=1 after edge k+1.
  - With OUT_READY tied high, the minimum issue interval is 3 cycles.
  - No new operation is accepted in the same cycle a result is consumed.
- Arithmetic (unsigned, modulo 2^WIDTH):
  - LOAD: ACC=DIN, C=0.
  - ADD: {C,ACC}=ACC+DIN.
  - SUB: ACC=ACC+~DIN+1 (two's-complement add through the same adder); C=borrow=NOT carry-out, i.e. C=1 iff old ACC<DIN.
  - CLEAR: ACC=0, C=0, OVF_STICKY=0; DIN is ignored.
- OVF_STICKY: next=OVF_STICKY|C for LOAD/ADD/SUB.
- Boundary cases:
  - ADD 31+1 gives ACC=0, C=1.
  - SUB 0-1 gives ACC=31, C=1.
  - SUB x-x gives ACC=0, C=0.
  - ADD 0+0 gives C=0.
- Handshake:
  - IN_VALID may drop without being accepted; OP/DIN are sampled only on the accept edge.
  - Changes to DIN after the accept edge have no effect.
  - OUT_READY outside HOLD is ignored.
- Outputs ACC, C, OVF_STICKY, OUT_VALID are driven directly from flip-flops. No combinational path exists from inputs to these outputs; IN_READY is decoded from state only.

Optional Feature:
- Macro: CLA5_ACC_SATURATE_EN.
- Defined:
  - ADD with carry-out clamps ACC to all ones (31).
  - SUB with borrow clamps ACC to 0.
  - C and OVF_STICKY are still set exactly as in wrap mode.
- Undefined: modulo wrap-around as specified above. No extra ports in either build.

Test Plan:
- Reset then LOAD 7 -> after accept edge+1: OUT_VALID=1, ACC=7, C=0, OVF_STICKY=0; OUT_READY=1 returns to IDLE, IN_READY=1 next cycle.
- LOAD 7, ADD 9, ADD 20 -> ACC=16 C=0, then ACC=4 C=1 OVF_STICKY=1 (saturate build: ACC=31 C=1).
- LOAD 4, SUB 5, SUB 31 -> ACC=31 C=1, then ACC=0 C=0 (saturate build: first SUB gives ACC=0 C=1, second SUB 31 gives ACC=0 C=1); OVF_STICKY=1 throughout; CLEAR -> ACC=0, C=0, OVF_STICKY=0.
- Backpressure: result ready with OUT_READY=0 for 4 cycles while IN_VALID=1 with new DIN -> ACC/C stable, OUT_VALID=1, IN_READY=0, no operand captured; the pending op is accepted only after OUT_READY pulse and return to IDLE.
- Reset mid-op: accept ADD 3 on ACC=10, assert RSTN=0 during COMPUTE -> ACC=0, C=0, OUT_VALID=0 immediately (asynchronous); after release, IN_READY=1 and no stale result appears.
- Sweep: all 32x32 ADD and SUB pairs from a LOAD -> ACC and C match reference model modulo 32 (or clamped in saturate build).

Source files
------------

// File: rtl/cla5_accumulator.sv
// -----------------------------------------------------------------------------
// cla5_accumulator
//
// Registered accumulator stage built around a carry-lookahead adder. An
// operation (opcode + operand) is accepted through a valid/ready handshake,
// evaluated against the current accumulator in the following cycle, and the
// result is then held until downstream consumes it.
//
// Operations (OP):
//   2'b00 LOAD  : ACC = DIN, C = 0
//   2'b01 ADD   : {C, ACC} = ACC + DIN
//   2'b10 SUB   : ACC = ACC + ~DIN + 1, C = borrow (ACC < DIN)
//   2'b11 CLEAR : ACC = 0, C = 0, OVF_STICKY = 0 (DIN ignored)
//
// Build option:
//   CLA5_ACC_SATURATE_EN - when defined, ADD with carry clamps ACC to all ones
//                          and SUB with borrow clamps ACC to zero. C and
//                          OVF_STICKY behave exactly as in wrap mode.
//
// Ports:
//   CLK        in   clock, rising edge
//   RSTN       in   asynchronous active-low reset
//   IN_VALID   in   upstream presents OP/DIN
//   IN_READY   out  block can accept an operation (IDLE and out of reset)
//   OP         in   opcode, see above
//   DIN        in   unsigned operand
//   OUT_VALID  out  ACC/C hold a fresh result (registered)
//   OUT_READY  in   downstream consumes the result (only honoured in HOLD)
//   ACC        out  accumulator value (registered)
//   C          out  carry/borrow of the last operation (registered)
//   OVF_STICKY out  set by any C=1 result, cleared by CLEAR or reset
// -----------------------------------------------------------------------------
module cla5_accumulator #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ACC,
    output logic             C,
    output logic             OVF_STICKY
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_din;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic             r_ovf;
    logic             r_out_valid;

    // -------------------------------------------------------------------------
    // Carry-lookahead adder: r_acc + w_b + w_cin
    // SUB reuses the adder by inverting the operand and injecting a carry-in.
    // -------------------------------------------------------------------------
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    assign w_is_sub = (r_op == OP_SUB);
    assign w_b      = w_is_sub ? ~r_din : r_din;
    assign w_cin    = w_is_sub;
    assign w_g      = r_acc & w_b;
    assign w_p      = r_acc ^ w_b;

    assign w_carry[0] = w_cin;

    // Each carry is a flat sum of products: a generate at bit j propagated
    // through every bit between j and the carry position, plus the carry-in
    // propagated through all lower bits. No carry depends on another carry.
    genvar gi, gj;
    generate
        for (gi = 1; gi <= WIDTH; gi++) begin : g_carry
            logic [gi:0] w_terms;
            for (gj = 0; gj < gi; gj++) begin : g_term
                if (gj == gi - 1) begin : g_direct
                    assign w_terms[gj] = w_g[gj];
                end else begin : g_prop
                    assign w_terms[gj] = w_g[gj] & (&w_p[gi-1:gj+1]);
                end
            end
            assign w_terms[gi] = w_cin & (&w_p[gi-1:0]);
            assign w_carry[gi] = |w_terms;
        end
    endgenerate

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sum
            assign w_sum[gi] = w_p[gi] ^ w_carry[gi];
        end
    endgenerate

    assign w_cout = w_carry[WIDTH];

    // -------------------------------------------------------------------------
    // Result selection for the COMPUTE edge
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_acc_next;
    logic             w_c_next;
    logic             w_ovf_next;

    always_comb begin
        w_acc_next = r_acc;
        w_c_next   = 1'b0;
        case (r_op)
            OP_LOAD: begin
                w_acc_next = r_din;
                w_c_next   = 1'b0;
            end
            OP_ADD: begin
                w_acc_next = w_sum;
                w_c_next   = w_cout;
`ifdef CLA5_ACC_SATURATE_EN
                if (w_cout) begin
                    w_acc_next = {WIDTH{1'b1}};
                end
`endif
            end
            OP_SUB: begin
                // Carry-out of ACC + ~DIN + 1 is set when no borrow occurred.
                w_acc_next = w_sum;
                w_c_next   = ~w_cout;
`ifdef CLA5_ACC_SATURATE_EN
                if (!w_cout) begin
                    w_acc_next = {WIDTH{1'b0}};
                end
`endif
            end
            default: begin
                w_acc_next = {WIDTH{1'b0}};
                w_c_next   = 1'b0;
            end
        endcase
        w_ovf_next = (r_op == OP_CLEAR) ? 1'b0 : (r_ovf | w_c_next);
    end

    // -------------------------------------------------------------------------
    // Control FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_din       <= {WIDTH{1'b0}};
            r_acc       <= {WIDTH{1'b0}};
            r_c         <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_op    <= OP;
                        r_din   <= DIN;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_acc       <= w_acc_next;
                    r_c         <= w_c_next;
                    r_ovf       <= w_ovf_next;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    // Consumption returns to IDLE; a new operation can only be
                    // accepted from the following cycle onwards.
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Gated with RSTN so the block never advertises readiness while held in
    // reset, even though the state register already reads IDLE.
    assign IN_READY   = RSTN & (r_state == S_IDLE);
    assign OUT_VALID  = r_out_valid;
    assign ACC        = r_acc;
    assign C          = r_c;
    assign OVF_STICKY = r_ovf;

endmodule
